cla_nibble_serial_adder: RTL and testbench
==========================================

// Module: cla_nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit add/subtract engine that time-shares one 4-bit CLA slice.
//  Processes one nibble per clock, LSB first, rippling carry through a flop.
//  The carry is formed from the slice's group propagate/generate outputs.
//  Sits between an operand source with a start/done handshake and the 4-bit CLA
//  datapath; it is the area-minimal alternative to the fully parallel adder.
// PARAMETERS
//  WIDTH   16  operand/result width; must be a multiple of 4, >= 8
//  NSLICE  WIDTH/4  derived localparam, not overridable: cycles of RUN
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only when busy==0
//  sub    in   1      0: a+b+cin; 1: a-b (b inverted, carry-in forced 1, cin ignored)
//  a      in   WIDTH  operand A, captured on accepted start
//  b      in   WIDTH  operand B, captured on accepted start
//  cin    in   1      carry-in for add, captured on accepted start
//  busy   out  1      1 while in RUN
//  done   out  1      single-cycle pulse; result valid
//  sum    out  WIDTH  result; holds after done until the next accepted start
//  cout   out  1      final carry (sub: 1 = no borrow)
//  ovf    out  1      signed two's-complement overflow
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; busy, done, cout and ovf are 0; sum=0;
//    slice index=0; carry flop=0. Reset mid-RUN aborts the operation and emits no done.
//  - FSM states and transitions:
//    IDLE -> RUN on start.
//    RUN -> RUN while idx < NSLICE-1; RUN -> DONE when idx == NSLICE-1.
//    DONE -> RUN on start (back-to-back); DONE -> IDLE otherwise.
//  - Accept: on the start edge, latch A <= a and B <= (sub ? ~b : b).
//    Also latch carry <= (sub ? 1 : cin), idx <= 0, and clear sum.
//  - RUN cycle k (idx = k): drive the slice with
//    A[4k+:4], B[4k+:4] and the carry flop.
//    Write the slice sum to sum[4k+:4].
//    Update carry <= blockg | (blockp & carry), then idx++.
//  - Latency: start accepted at edge T0 -> done=1 during the cycle after edge T0+NSLICE.
//    busy is high for exactly NSLICE cycles.
//  - done is asserted only in DONE. busy is asserted only in RUN.
//  - cout and ovf are registered on the last RUN edge.
//    ovf = (A[W-1] == B[W-1]) & (sum[W-1] != A[W-1]), using the latched (inverted) B.
//  - start while busy is ignored: no effect, and operands are not recaptured.
//  - Inputs a, b, sub and cin may change freely after acceptance.
//  - sum is undefined (partial) while busy. It is final only when done==1.
//  - idx wraps to 0 on leaving RUN. There is no wrap within an operation.
// STRUCTURE
//  - Shared package/header: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
//    Also the nibble width constant 4.
//  - One sub-module instance: cla_slice4 (a, b, cin -> sum, blockp, blockg).
//    It is the team's existing 4-bit CLA slice. The slice's own sum uses its
//    internal ripple; this block forms the inter-nibble carry itself.
//  - Index counter width: $clog2(NSLICE).
//  - Operand and result storage use indexed part-selects, not shift registers.
// TESTING (WIDTH=16)
//  - Plain add, no carry:
//    a=0x1234, b=0x4321, sub=0, cin=0 -> sum=0x5555, cout=0, ovf=0.
//    busy high for 4 cycles; done is a single pulse 5 cycles after the start edge.
//  - Carry through all slices:
//    a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0.
//    Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
//  - Signed overflow:
//    a=0x7FFF, b=0x0001 add -> sum=0x8000, ovf=1, cout=0.
//    a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1, cout=1.
//  - Subtract with borrow:
//    a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
//  - Handshake: start held high continuously with 0x0001+0x0001 then 0x0002+0x0002.
//    Mid-RUN start pulses are ignored; back-to-back from DONE gives sum=0x0002
//    then sum=0x0004, with done pulses 5 cycles apart.
//  - Reset: assert rst during RUN cycle 2 of 0xFFFF+0x0001 -> outputs 0 immediately.
//    No done is produced. A subsequent start computes 0x0010+0x0020=0x0030 correctly.
//  - The bench compares against a behavioural {cout,sum} = a + b_eff + c_eff model.
//    Randomised add/sub vectors are run in addition to the directed cases.

Source files
------------

// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial CLA add/subtract engine:
// FSM state encodings and the slice width.
package cla_nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_nibble_serial_adder_if.sv
// Start/done request bus between an operand source and the serial adder.
interface cla_nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/cla_slice4.sv
// 4-bit CLA slice: internal ripple for the sum, group propagate/generate
// outputs so the caller can form the carry out of the slice.
module cla_slice4
  import cla_nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             blockp,
  output logic             blockg
);

  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < NIB_W - 1; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum    = p ^ c;
    blockp = &p;
    blockg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// WIDTH-bit add/subtract engine that reuses one 4-bit CLA slice, one nibble
// per clock LSB first, with the inter-nibble carry held in a flop.
module cla_nibble_serial_adder
  import cla_nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  cla_nibble_serial_adder_if.slave  bus
);

  localparam int NSLICE = WIDTH / NIB_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t             state_q;
  state_t             state_d;
  logic               accept;
  logic               run;
  logic               last;

  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;

  logic [NIB_W-1:0]   slice_a;
  logic [NIB_W-1:0]   slice_b;
  logic [NIB_W-1:0]   slice_sum;
  logic               blockp;
  logic               blockg;
  logic               carry_nxt;

  assign run  = (state_q == RUN);
  assign last = run && (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          state_d = RUN;
          accept  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // slice stage: current nibble of each operand plus the carry flop
  assign slice_a = opa_q[{idx_q, 2'b00} +: NIB_W];
  assign slice_b = opb_q[{idx_q, 2'b00} +: NIB_W];

  cla_slice4 u_slice (
    .a      (slice_a),
    .b      (slice_b),
    .cin    (carry_q),
    .sum    (slice_sum),
    .blockp (blockp),
    .blockg (blockg)
  );

  assign carry_nxt = blockg | (blockp & carry_q);

  // Operands only matter after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa_q <= bus.a;
      opb_q <= bus.sub ? ~bus.b : bus.b;
    end
  end

  // result stage: nibble write-back, carry chain and final flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      carry_q <= bus.sub | bus.cin;
      sum_q   <= '0;
    end else if (run) begin
      sum_q[{idx_q, 2'b00} +: NIB_W] <= slice_sum;
      carry_q <= carry_nxt;
      if (last) begin
        idx_q  <= '0;
        cout_q <= carry_nxt;
        ovf_q  <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                  (slice_sum[NIB_W-1] != opa_q[WIDTH-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign bus.busy = run;
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Scoreboard bench for cla_nibble_serial_adder at WIDTH=16: directed vectors
// with hand-computed results, handshake/reset scenarios and model-checked randoms.
module tb_cla_nibble_serial_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sbq[$];

  cla_nibble_serial_adder_if #(.WIDTH(16)) bus ();

  cla_nibble_serial_adder #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none at t=%0t", $time);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sum", 32'(bus.sum), 32'(e.sum));
        chk("cout", 32'(bus.cout), 32'(e.cout));
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
      end
    end
  end

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic c);
    logic [15:0] be;
    logic [16:0] r;
    exp_t e;
    be     = s ? ~b : b;
    r      = {1'b0, a} + {1'b0, be} + 17'(s | c);
    e.sum  = r[15:0];
    e.cout = r[16];
    e.ovf  = (a[15] == be[15]) && (r[15] != a[15]);
    return e;
  endfunction

  task automatic wait_done(input string name);
    int guard = 0;
    while (bus.done !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (bus.done !== 1'b1) chk({name, "_timeout"}, 32'(bus.done), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic c, input exp_t e, input bit glitch);
    int n;
    int guard;
    bus.a = a; bus.b = b; bus.sub = s; bus.cin = c; bus.start = 1'b1;
    sbq.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.sub = ~s; bus.cin = ~c;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    n = 1;
    guard = 0;
    while (bus.busy === 1'b1 && guard < 20) begin
      bus.start = glitch && (n == 2);
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.busy === 1'b1) n++;
      guard++;
    end
    chk("busy_cycles", 32'(n), 32'd4);
    chk("done_latency", 32'(bus.done), 32'd1);
    @(posedge clk); #1;
    chk("done_single_pulse", 32'(bus.done), 32'd0);
    chk("sum_hold", 32'(bus.sum), 32'(e.sum));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int t1;
    int t2;
    bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, expectations worked by hand.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}, 1'b1);
    run_op(16'hFFFF, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b1}, 1'b0);

    // Reset mid-operation: cout/ovf are still 1 from the previous op.
    bus.a = 16'hFFFF; bus.b = 16'h0001; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", 32'(bus.busy), 32'd0);
    chk("midrun_rst_done", 32'(bus.done), 32'd0);
    chk("midrun_rst_sum", 32'(bus.sum), 32'd0);
    chk("midrun_rst_cout", 32'(bus.cout), 32'd0);
    chk("midrun_rst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.busy), 32'd0);
    run_op(16'h0010, 16'h0020, 1'b0, 1'b0, '{16'h0030, 1'b0, 1'b0}, 1'b0);

    // Back-to-back with start held high throughout.
    bus.a = 16'h0001; bus.b = 16'h0001; bus.sub = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
    sbq.push_back('{16'h0002, 1'b0, 1'b0});
    sbq.push_back('{16'h0004, 1'b0, 1'b0});
    @(posedge clk); #1;
    bus.a = 16'h0002; bus.b = 16'h0002;
    wait_done("b2b_first");
    t1 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_rearm_busy", 32'(bus.busy), 32'd1);
    wait_done("b2b_second");
    t2 = cyc;
    chk("b2b_done_spacing", 32'(t2 - t1), 32'd5);
    @(posedge clk); #1;

    // Random add/sub against the behavioural model.
    for (int i = 0; i < 10; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      logic        rc;
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom); rc = 1'($urandom);
      run_op(ra, rb, rs, rc, model(ra, rb, rs, rc), 1'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
